// File: rtl/xadc_disp_pkg.sv
// Shared types and constants for the XADC-to-7-segment scaling path.
// Also holds the add-3 correction used by the sequential binary-to-BCD converter.
package xadc_disp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ACCUM,
      SCALE,
      CONVERT,
      DONE
   } scaler_state_t;

   localparam int ADC_BITS   = 12;
   localparam int MV_BITS    = 14;
   localparam int BCD_DIGITS = 4;
   localparam int BCD_BITS   = 4 * BCD_DIGITS;
   localparam int MV_MAX     = 9999;
   localparam int PROD_BITS  = 26;

   // Any digit >= 5 would overflow past 9 on the next shift, so bias it by 3 first.
   function automatic logic [BCD_BITS-1:0] dabble_adjust(input logic [BCD_BITS-1:0] bcd);
      logic [BCD_BITS-1:0] res;
      res = bcd;
      for (int d = 0; d < BCD_DIGITS; d++) begin
         if (bcd[4*d +: 4] >= 4'd5) begin
            res[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, MV_BITS shifts per result.
// done is high during the cycle whose closing edge performs the final shift.
module bin2bcd_seq
   import xadc_disp_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [MV_BITS-1:0]  bin,
   output logic [BCD_BITS-1:0] bcd,
   output logic                done
);

   localparam int CNT_W = 4;

   logic [BCD_BITS-1:0] bcd_sr;
   logic [MV_BITS-1:0]  bin_sr;
   logic [CNT_W-1:0]    shift_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         bcd_sr    <= '0;
         bin_sr    <= '0;
         shift_cnt <= '0;
      end else if (start) begin
         bcd_sr    <= '0;
         bin_sr    <= bin;
         shift_cnt <= CNT_W'(MV_BITS);
      end else if (shift_cnt != '0) begin
         {bcd_sr, bin_sr} <= {dabble_adjust(bcd_sr), bin_sr} << 1;
         shift_cnt        <= shift_cnt - CNT_W'(1);
      end
   end

   assign bcd  = bcd_sr;
   assign done = (shift_cnt == CNT_W'(1));

endmodule

// File: rtl/adc_bcd_scaler.sv
// Averages XADC codes, scales them to millivolts and hands the result to the
// sequential BCD converter; BCD_out only changes on the BCD_Valid strobe.
//
// state   | meaning
// IDLE    | waiting for the first sample of a block
// ACCUM   | block partially accumulated, waiting for more samples
// SCALE   | average, scale to mV, clamp, load converter
// CONVERT | converter shifting (14 cycles)
// DONE    | capture converter result, pulse BCD_Valid
module adc_bcd_scaler
   import xadc_disp_pkg::*;
#(
   parameter int AVG_LOG2 = 0,
   parameter int FS_MV    = 1000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [15:0] Data_in,
   input  logic        Data_Valid,
   output logic [15:0] BCD_out,
   output logic        BCD_Valid,
   output logic        Busy,
   output logic        Overrun
);

   localparam int ACC_W = ADC_BITS + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam int NSAMP = 1 << AVG_LOG2;

   scaler_state_t state, state_next;

   logic [ACC_W-1:0]     acc;
   logic [CNT_W-1:0]     cnt;
   logic [ADC_BITS-1:0]  code;
   logic                 unused_low;
   logic                 take;
   logic                 last;
   logic [ADC_BITS-1:0]  avg;
   logic [PROD_BITS-1:0] product;
   logic [MV_BITS-1:0]   mv_raw;
   logic [MV_BITS-1:0]   mv;
   logic                 conv_start;
   logic                 conv_done;
   logic [BCD_BITS-1:0]  conv_bcd;

   assign code       = Data_in[15:4];
   assign unused_low = ^Data_in[3:0];

   assign take = Data_Valid && ((state == IDLE) || (state == ACCUM));
   assign last = take && (cnt == CNT_W'(NSAMP - 1));

   assign avg     = acc[ACC_W-1:AVG_LOG2];
   assign product = PROD_BITS'(avg) * PROD_BITS'(FS_MV);
   assign mv_raw  = product[PROD_BITS-1:ADC_BITS];
   assign mv      = (mv_raw > MV_BITS'(MV_MAX)) ? MV_BITS'(MV_MAX) : mv_raw;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      conv_start = 1'b0;
      Busy       = 1'b0;
      case (state)
         IDLE: begin
            if (take) begin
               state_next = last ? SCALE : ACCUM;
            end
         end
         ACCUM: begin
            if (last) begin
               state_next = SCALE;
            end
         end
         SCALE: begin
            Busy       = 1'b1;
            conv_start = 1'b1;
            state_next = CONVERT;
         end
         CONVERT: begin
            Busy = 1'b1;
            if (conv_done) begin
               state_next = DONE;
            end
         end
         DONE: begin
            Busy       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         acc <= '0;
         cnt <= '0;
      end else if (state == SCALE) begin
         acc <= '0;
         cnt <= '0;
      end else if (take) begin
         acc <= acc + ACC_W'(code);
         cnt <= cnt + CNT_W'(1);
      end
   end

   bin2bcd_seq u_bin2bcd (
      .clk   (Clk),
      .reset (Reset),
      .start (conv_start),
      .bin   (mv),
      .bcd   (conv_bcd),
      .done  (conv_done)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         BCD_out   <= '0;
         BCD_Valid <= 1'b0;
         Overrun   <= 1'b0;
      end else begin
         BCD_Valid <= (state == DONE);
         if (state == DONE) begin
            BCD_out <= conv_bcd;
         end
         // Busy covers DONE as well, so a strobe in the capture cycle also counts.
         if (Data_Valid && Busy) begin
            Overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_adc_bcd_scaler.sv
// Self-checking bench for adc_bcd_scaler: three parameterisations checked against
// an arithmetic millivolt/decimal reference model.
module tb_adc_bcd_scaler;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [15:0] din  [3];
   logic        dv   [3];
   logic [15:0] bcd  [3];
   logic        bv   [3];
   logic        busy [3];
   logic        ovr  [3];

   int lg_of [3] = '{0, 2, 1};
   int fs_of [3] = '{1000, 1000, 3300};

   logic [11:0] blk [16];
   int n_tests = 0;
   int n_fail  = 0;

   always #5 Clk = ~Clk;

   adc_bcd_scaler #(.AVG_LOG2(0), .FS_MV(1000)) dut_a (
      .Clk(Clk), .Reset(Reset), .Data_in(din[0]), .Data_Valid(dv[0]),
      .BCD_out(bcd[0]), .BCD_Valid(bv[0]), .Busy(busy[0]), .Overrun(ovr[0]));

   adc_bcd_scaler #(.AVG_LOG2(2), .FS_MV(1000)) dut_b (
      .Clk(Clk), .Reset(Reset), .Data_in(din[1]), .Data_Valid(dv[1]),
      .BCD_out(bcd[1]), .BCD_Valid(bv[1]), .Busy(busy[1]), .Overrun(ovr[1]));

   adc_bcd_scaler #(.AVG_LOG2(1), .FS_MV(3300)) dut_c (
      .Clk(Clk), .Reset(Reset), .Data_in(din[2]), .Data_Valid(dv[2]),
      .BCD_out(bcd[2]), .BCD_Valid(bv[2]), .Busy(busy[2]), .Overrun(ovr[2]));

   // Reference: mean of the block, scaled to mV with truncation, clamped, as decimal digits.
   function automatic logic [15:0] model(input int sum, input int lg, input int fs);
      int avg, mv;
      avg = sum >> lg;
      mv  = (avg * fs) / 4096;
      if (mv > 9999) mv = 9999;
      return {4'(mv / 1000), 4'((mv / 100) % 10), 4'((mv / 10) % 10), 4'(mv % 10)};
   endfunction

   // Sends blk[0..n-1] to one DUT, then checks latency, value, hold and strobe width.
   // poke_at > 0 raises Data_Valid for one cycle that many clocks after the final accept.
   task automatic run_block(input int idx, input int n, input int gap, input int poke_at,
                            input string name);
      int          sum  = 0;
      int          lat  = 0;
      bit          held = 1'b1;
      logic [15:0] old;
      logic [15:0] expv;
      old = bcd[idx];
      for (int i = 0; i < n; i++) begin
         din[idx] = {blk[i], 4'($urandom_range(0, 15))};
         dv[idx]  = 1'b1;
         @(posedge Clk); #1;
         dv[idx] = 1'b0;
         sum += int'(blk[i]);
         if (i < n - 1) begin
            n_tests++;
            if (bv[idx] !== 1'b0 || busy[idx] !== 1'b0) begin
               n_fail++;
               $display("FAIL %s partial_block dut=%0d sample=%0d valid=%b busy=%b required valid=0 busy=0",
                        name, idx, i, bv[idx], busy[idx]);
            end
            for (int g = 0; g < gap; g++) begin
               @(posedge Clk); #1;
            end
         end
      end
      expv = model(sum, lg_of[idx], fs_of[idx]);
      for (int k = 1; k <= 40; k++) begin
         @(posedge Clk); #1;
         if (k == 1) begin
            n_tests++;
            if (busy[idx] !== 1'b1) begin
               n_fail++;
               $display("FAIL %s busy_after_accept dut=%0d got=%b required=1", name, idx, busy[idx]);
            end
         end
         if (bv[idx] === 1'b1) begin
            lat     = k;
            dv[idx] = 1'b0;
            break;
         end
         if (bcd[idx] !== old) held = 1'b0;
         dv[idx] = (k == poke_at);
         if (k == poke_at) din[idx] = 16'($urandom);
      end
      dv[idx] = 1'b0;
      n_tests++;
      if (lat != 16) begin
         n_fail++;
         $display("FAIL %s latency dut=%0d got=%0d required=16 (0 = no strobe)", name, idx, lat);
      end
      n_tests++;
      if (bcd[idx] !== expv) begin
         n_fail++;
         $display("FAIL %s value dut=%0d got=%h required=%h", name, idx, bcd[idx], expv);
      end
      n_tests++;
      if (!held) begin
         n_fail++;
         $display("FAIL %s output_changed_before_strobe dut=%0d old=%h", name, idx, old);
      end
      @(posedge Clk); #1;
      n_tests++;
      if (bv[idx] !== 1'b0 || bcd[idx] !== expv || busy[idx] !== 1'b0) begin
         n_fail++;
         $display("FAIL %s after_strobe dut=%0d valid=%b bcd=%h busy=%b required 0/%h/0",
                  name, idx, bv[idx], bcd[idx], busy[idx], expv);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         dv[i]  = 1'b0;
         din[i] = 16'h0000;
      end
      repeat (3) @(posedge Clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (bcd[i] !== 16'h0000 || bv[i] !== 1'b0 || busy[i] !== 1'b0 || ovr[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset dut=%0d bcd=%h valid=%b busy=%b overrun=%b required 0000/0/0/0",
                     i, bcd[i], bv[i], busy[i], ovr[i]);
         end
      end
      Reset = 1'b0;
      @(posedge Clk); #1;
   endtask

   task automatic test_full_scale();
      blk[0] = 12'hFFF;
      run_block(0, 1, 0, 0, "full_scale");
      n_tests++;
      if (bcd[0] !== 16'h0999) begin
         n_fail++;
         $display("FAIL full_scale_const got=%h required=0999", bcd[0]);
      end
   endtask

   task automatic test_codes();
      logic [11:0] codes [3] = '{12'h800, 12'h000, 12'h001};
      logic [15:0] want  [3] = '{16'h0500, 16'h0000, 16'h0000};
      for (int i = 0; i < 3; i++) begin
         blk[0] = codes[i];
         run_block(0, 1, 1, 0, "single_code");
         n_tests++;
         if (bcd[0] !== want[i]) begin
            n_fail++;
            $display("FAIL single_code_const code=%h got=%h required=%h", codes[i], bcd[0], want[i]);
         end
      end
   endtask

   task automatic test_average();
      blk[0] = 12'h400; blk[1] = 12'h400; blk[2] = 12'hC00; blk[3] = 12'hC00;
      run_block(1, 4, 2, 0, "average4");
      n_tests++;
      if (bcd[1] !== 16'h0500) begin
         n_fail++;
         $display("FAIL average4_const got=%h required=0500", bcd[1]);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) blk[i] = 12'($urandom);
      run_block(1, 4, 0, 0, "back_to_back4");
      for (int i = 0; i < 2; i++) blk[i] = 12'($urandom);
      run_block(2, 2, 0, 0, "back_to_back2");
   endtask

   task automatic test_overrun();
      blk[0] = 12'h5A5;
      run_block(0, 1, 0, 5, "poke_convert");
      n_tests++;
      if (ovr[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_set got=%b required=1", ovr[0]);
      end
      blk[0] = 12'h800;
      run_block(0, 1, 2, 0, "after_overrun");
      n_tests++;
      if (ovr[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_sticky got=%b required=1", ovr[0]);
      end
      n_tests++;
      if (ovr[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_clean dut=1 got=%b required=0", ovr[1]);
      end
      for (int i = 0; i < 4; i++) blk[i] = 12'($urandom);
      run_block(1, 4, 1, 15, "poke_done");
      n_tests++;
      if (ovr[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_done got=%b required=1", ovr[1]);
      end
      for (int i = 0; i < 4; i++) blk[i] = 12'($urandom);
      run_block(1, 4, 1, 0, "after_done_drop");
   endtask

   task automatic test_reset_mid();
      bit seen = 1'b0;
      din[0] = 16'hABC0;
      dv[0]  = 1'b1;
      @(posedge Clk); #1;
      dv[0] = 1'b0;
      repeat (5) begin
         @(posedge Clk); #1;
      end
      Reset = 1'b1;
      @(posedge Clk); #1;
      Reset = 1'b0;
      n_tests++;
      if (bcd[0] !== 16'h0000 || busy[0] !== 1'b0 || ovr[0] !== 1'b0 || bv[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid dut=0 bcd=%h busy=%b overrun=%b valid=%b required 0000/0/0/0",
                  bcd[0], busy[0], ovr[0], bv[0]);
      end
      for (int k = 0; k < 20; k++) begin
         @(posedge Clk); #1;
         if (bv[0] === 1'b1) seen = 1'b1;
      end
      n_tests++;
      if (seen) begin
         n_fail++;
         $display("FAIL reset_mid_no_strobe got=1 required=0");
      end
      blk[0] = 12'h400;
      run_block(0, 1, 0, 0, "after_reset");
      n_tests++;
      if (bcd[0] !== 16'h0250) begin
         n_fail++;
         $display("FAIL after_reset_const got=%h required=0250", bcd[0]);
      end
   endtask

   task automatic test_random();
      for (int rep = 0; rep < 8; rep++) begin
         for (int idx = 0; idx < 3; idx++) begin
            int n;
            n = 1 << lg_of[idx];
            for (int i = 0; i < n; i++) begin
               case ($urandom_range(0, 7))
                  0:       blk[i] = 12'hFFF;
                  1:       blk[i] = 12'h000;
                  default: blk[i] = 12'($urandom);
               endcase
            end
            run_block(idx, n, $urandom_range(0, 3), 0, "random");
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_scale();
      test_codes();
      test_average();
      test_back_to_back();
      test_overrun();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
